sensor_arbiter: RTL
===================

SENSOR_ARBITER -- requirements
Module: sensor_arbiter

Interface
REQ-001 Parameter N_SENSORS, 4, number of digital sensor request channels (2..14).
REQ-002 Parameter TEMP_W, 6, temperature width in bits.
REQ-003 Parameter T_LOW, 20, heater request when temperature < T_LOW; constraint T_LOW <= T_HIGH.
REQ-004 Parameter T_HIGH, 30, cooler request when temperature > T_HIGH.
REQ-005 Parameter MIN_HOLD, 4, minimum grant duration in cycles (>= 1).
REQ-006 Parameter ALT_LOG2, 3, width of the alternating-priority counter.
REQ-007 Derived: NCH = N_SENSORS+2; IDX_W = clog2(NCH).
REQ-008 clk  input  1  single clock; all logic is rising-edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 sensor_req  input  N_SENSORS  per-channel requests; bit 0 is channel 0.
REQ-011 temp_valid  input  1  temperature sensor enabled; gates channels N_SENSORS and N_SENSORS+1.
REQ-012 temperature  input  TEMP_W  unsigned temperature reading.
REQ-013 mode  input  2  00 fixed low-first, 01 fixed high-first, 10 round-robin, 11 alternating.
REQ-014 grant  output  NCH  one-hot registered grant.
REQ-015 grant_idx  output  IDX_W  index of the granted channel (display); 0 when none.
REQ-016 grant_valid  output  1  high when any grant bit is set.
REQ-017 rev_flag  output  1  MSB of the alternating counter.

Function
REQ-018 req vector: bits [N_SENSORS-1:0] = sensor_req; bit N_SENSORS = temp_valid & (temperature < T_LOW); bit N_SENSORS+1 = temp_valid & (temperature > T_HIGH).
REQ-019 Inputs are sampled combinationally; grant, grant_idx and grant_valid update on the next rising edge (latency 1 cycle).
REQ-020 FSM states: IDLE (no grant), HOLD (grant locked, hold counter running), OPEN (grant live, re-arbitrated every cycle).
REQ-021 IDLE: req==0 -> stay IDLE; otherwise grant the winner -> HOLD, with hold counter = MIN_HOLD-1.
REQ-022 HOLD: grant unchanged regardless of req, including deasserted requests; decrement counter; at 0 -> OPEN; MIN_HOLD=1 -> OPEN directly from IDLE.
REQ-023 OPEN: req==0 -> IDLE, grant cleared; winner equals current grant -> stay OPEN; different winner -> new grant, HOLD reloaded.
REQ-024 Winner mode 00: lowest set index; mode 01: highest set index.
REQ-025 Winner mode 10: first set index at or above rr_ptr, wrapping NCH-1 -> 0; rr_ptr = granted index+1 mod NCH, updated on every new grant.
REQ-026 Winner mode 11: rev_flag=0 behaves as mode 00, rev_flag=1 as mode 01.
REQ-027 Alternating counter increments, wrapping, on every cycle with req != 0 in any mode.
REQ-028 Mode changes during HOLD take effect at the next arbitration only.
REQ-029 grant is always zero or one-hot; grant_idx is consistent with grant in the same cycle.
REQ-030 Heater and cooler requests are never simultaneously set, because comparisons are strict.

Reset
REQ-031 reset high at a rising edge: state IDLE; grant, grant_idx, grant_valid, rev_flag, rr_ptr, hold counter and alternating counter = 0.
REQ-032 reset overrides any state, including mid-HOLD; first possible grant is the edge after reset deasserts.

Configuration
REQ-033 Macro SENSOR_ARBITER_HOLD_EN defined: HOLD state and MIN_HOLD behave as above.
REQ-034 Macro undefined: no HOLD state; every new grant goes directly to OPEN (re-arbitrate each cycle); MIN_HOLD ignored.

Verification
REQ-035 Reset held 3 cycles with all req=1 -> grant=0, grant_idx=0, grant_valid=0 throughout; 1 cycle after release, mode 00 -> grant=000001.
REQ-036 Mode 00, req=0b0110 then 0b0001 on the next cycle (HOLD_EN, MIN_HOLD=4) -> grant=000010 for 4 cycles, then 000001.
REQ-037 Mode 10, sensor_req=4'b1111 constant (4 sensors, temp_valid=0) -> grant_idx=0,1,2,3,0 with each grant lasting 4 cycles.
REQ-038 temp_valid=1, temperature=10 -> grant bit 4 (heater), grant_idx=4; temperature=35 -> bit 5 (cooler); temperature=25 -> no temperature request.
REQ-039 Mode 11, ALT_LOG2=3, req=0b000101 constant -> grant=000001 while rev_flag=0, then grant=000100 after rev_flag rises on the 4th requesting cycle (subject to hold).
REQ-040 reset asserted mid-HOLD -> all outputs 0 on the next edge; macro undefined build: req alternating 0b01/0b10 each cycle -> grant follows with 1-cycle latency.

Source files
------------

// File: rtl/sensor_arbiter.sv
// Arbiter over N_SENSORS digital request lines plus heater/cooler requests derived from a temperature.
// Define SENSOR_ARBITER_HOLD_EN to lock each new grant for MIN_HOLD cycles before re-arbitration.
module sensor_arbiter #(
  parameter int N_SENSORS = 4,
  parameter int TEMP_W    = 6,
  parameter int T_LOW     = 20,
  parameter int T_HIGH    = 30,
  parameter int MIN_HOLD  = 4,
  parameter int ALT_LOG2  = 3,
  localparam int NCH      = N_SENSORS + 2,
  localparam int IDX_W    = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SENSORS-1:0] sensor_req,
  input  logic                 temp_valid,
  input  logic [TEMP_W-1:0]    temperature,
  input  logic [1:0]           mode,
  output logic [NCH-1:0]       grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_valid,
  output logic                 rev_flag
);

`ifdef SENSOR_ARBITER_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  // MIN_HOLD of 1 means no locked cycles beyond the grant cycle itself, so HOLD is skipped.
  localparam bit                USE_HOLD  = HOLD_EN && (MIN_HOLD > 1);
  localparam int                HOLD_W    = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((MIN_HOLD > 1) ? (MIN_HOLD - 1) : 0);
  localparam logic [TEMP_W-1:0] T_LOW_V   = TEMP_W'(T_LOW);
  localparam logic [TEMP_W-1:0] T_HIGH_V  = TEMP_W'(T_HIGH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NCH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_OPEN = 2'd2;

  logic [1:0]          r_state;
  logic [NCH-1:0]      r_grant;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [HOLD_W-1:0]   r_hold;
  logic [ALT_LOG2-1:0] r_alt;

  logic [NCH-1:0]      w_req;
  logic                w_any;
  logic [IDX_W-1:0]    w_low_idx;
  logic [IDX_W-1:0]    w_high_idx;
  logic [IDX_W-1:0]    w_rr_idx;
  logic [IDX_W-1:0]    w_win;
  logic [NCH-1:0]      w_win_onehot;
  logic                w_use_high;
  logic                w_take;

  genvar gi;
  generate
    for (gi = 0; gi < N_SENSORS; gi++) begin : g_sens
      assign w_req[gi] = sensor_req[gi];
    end
  endgenerate

  // Strict comparisons keep heater and cooler mutually exclusive since T_LOW <= T_HIGH.
  assign w_req[N_SENSORS]   = temp_valid && (temperature < T_LOW_V);
  assign w_req[N_SENSORS+1] = temp_valid && (temperature > T_HIGH_V);
  assign w_any              = |w_req;

  always_comb begin
    logic [IDX_W-1:0] v_j;
    w_low_idx  = '0;
    w_high_idx = '0;
    w_rr_idx   = '0;
    v_j        = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_req[IDX_W'(i)]) w_low_idx = IDX_W'(i);
    end
    for (int i = 0; i < NCH; i++) begin
      if (w_req[IDX_W'(i)]) w_high_idx = IDX_W'(i);
    end
    // Scan downward so the nearest requester at or after the pointer wins last.
    for (int k = NCH - 1; k >= 0; k--) begin
      v_j = IDX_W'((int'(r_rr_ptr) + k) % NCH);
      if (w_req[v_j]) w_rr_idx = v_j;
    end
  end

  assign w_use_high = (mode == 2'b01) || ((mode == 2'b11) && rev_flag);

  always_comb begin
    if (mode == 2'b10) begin
      w_win = w_rr_idx;
    end else if (w_use_high) begin
      w_win = w_high_idx;
    end else begin
      w_win = w_low_idx;
    end
  end

  assign w_win_onehot = {{(NCH-1){1'b0}}, 1'b1} << w_win;
  assign w_take       = w_any && ((r_state == S_IDLE) ||
                                  ((r_state == S_OPEN) && (w_win != r_idx)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_idx    <= '0;
      r_rr_ptr <= '0;
      r_hold   <= '0;
      r_alt    <= '0;
    end else begin
      if (w_any) r_alt <= r_alt + 1'b1;
      if (w_take) begin
        r_grant  <= w_win_onehot;
        r_idx    <= w_win;
        r_rr_ptr <= (w_win == LAST_IDX) ? '0 : (w_win + 1'b1);
        if (USE_HOLD) begin
          r_state <= S_HOLD;
          r_hold  <= HOLD_LOAD;
        end else begin
          r_state <= S_OPEN;
        end
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_IDLE;
          S_HOLD: begin
            if (r_hold <= HOLD_W'(1)) begin
              r_state <= S_OPEN;
              r_hold  <= '0;
            end else begin
              r_hold <= r_hold - 1'b1;
            end
          end
          S_OPEN: begin
            if (!w_any) begin
              r_state <= S_IDLE;
              r_grant <= '0;
              r_idx   <= '0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_hold  <= '0;
          end
        endcase
      end
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = r_idx;
  assign grant_valid = |r_grant;
  assign rev_flag    = r_alt[ALT_LOG2-1];

endmodule
